// File: rtl/gmux_sel_ctrl_if.sv
// Request handshake and GMUX-side outputs of the select sequencer.
// The slave modport belongs to the sequencer. The master modport belongs to the requester.
interface gmux_sel_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             req_vld;
    logic             req_sel;
    logic             req_rdy;
    logic             is0;
    logic             cen;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sw_cnt;

    modport slave (
        input  req_vld, req_sel,
        output req_rdy, is0, cen, busy, done, sw_cnt
    );

    modport master (
        output req_vld, req_sel,
        input  req_rdy, is0, cen, busy, done, sw_cnt
    );
endinterface

// File: rtl/gmux_sel_ctrl.sv
// Sequencer for the GMUX IS0 select.
// It gates CEN low, waits for quiescence, flips IS0, waits to settle, then re-enables CEN.
module gmux_sel_ctrl #(
    parameter int GATE_CYC   = 4,
    parameter int SETTLE_CYC = 4,
    parameter bit RESET_SEL  = 1'b0,
    parameter int CNT_W      = 8
) (
    input logic               clk,
    input logic               rst,
    gmux_sel_ctrl_if.slave    bus
);

    localparam int MAX_CYC = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
    localparam int TW      = $clog2(MAX_CYC + 1);

    if (GATE_CYC < 1) begin : g_bad_gate
        $error("GATE_CYC must be >= 1");
    end
    if (SETTLE_CYC < 1) begin : g_bad_settle
        $error("SETTLE_CYC must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("CNT_W must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        SETTLE
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             is0_q, is0_d;
    logic             cen_q, cen_d;
    logic             done_q, done_d;
    logic             sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    assign bus.req_rdy = (state_q == IDLE) && !rst;
    assign accept      = bus.req_vld && bus.req_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            is0_q   <= RESET_SEL;
            cen_q   <= 1'b1;
            done_q  <= 1'b0;
            sel_q   <= RESET_SEL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            is0_q   <= is0_d;
            cen_q   <= cen_d;
            done_q  <= done_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        is0_d   = is0_q;
        cen_d   = cen_q;
        done_d  = 1'b0;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // A request for the current source completes at once, without touching CEN.
                    if (bus.req_sel == is0_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = GATE;
                        cen_d   = 1'b0;
                        timer_d = TW'(GATE_CYC - 1);
                        sel_d   = bus.req_sel;
                    end
                end
            end
            GATE: begin
                if (timer_q == '0) begin
                    is0_d   = sel_q;
                    state_d = SETTLE;
                    timer_d = TW'(SETTLE_CYC - 1);
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            SETTLE: begin
                if (timer_q == '0) begin
                    cen_d   = 1'b1;
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.is0    = is0_q;
    assign bus.cen    = cen_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
    assign bus.sw_cnt = cnt_q;

endmodule

// File: tb/tb_gmux_sel_ctrl.sv
// Randomised bench for gmux_sel_ctrl, with an 8-bit counter instance and a 2-bit counter instance.
// The reference model tracks each switch as a count of cycles left, rather than as FSM states.
module tb_gmux_sel_ctrl;

    localparam int G = 4;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gmux_sel_ctrl_if #(.CNT_W(8)) bus8 ();
    gmux_sel_ctrl_if #(.CNT_W(2)) bus2 ();

    gmux_sel_ctrl #(.GATE_CYC(G), .SETTLE_CYC(S), .RESET_SEL(1'b0), .CNT_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    gmux_sel_ctrl #(.GATE_CYC(G), .SETTLE_CYC(S), .RESET_SEL(1'b0), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int   n_checks = 0;
    int   n_fail   = 0;

    int   m_left = 0;
    int   m_cnt  = 0;
    logic m_is0  = 1'b0;
    logic m_cen  = 1'b1;
    logic m_done = 1'b0;
    logic m_pend = 1'b0;

    bit   started = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic s);
        rst          = r;
        bus8.req_vld = v;
        bus8.req_sel = s;
        bus2.req_vld = v;
        bus2.req_sel = s;
        #1;
        check("req_rdy", 32'(bus8.req_rdy), 32'(!r && m_left == 0));
        check("req_rdy_w2", 32'(bus2.req_rdy), 32'(!r && m_left == 0));
        check("busy", 32'(bus8.busy), 32'(m_left > 0));
        @(posedge clk);
        m_done = 1'b0;
        if (r) begin
            m_left = 0;
            m_is0  = 1'b0;
            m_cen  = 1'b1;
            m_cnt  = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == S) m_is0 = m_pend;
            if (m_left == 0) begin
                m_cen  = 1'b1;
                m_done = 1'b1;
                m_cnt++;
            end
        end else if (v) begin
            if (s == m_is0) begin
                m_done = 1'b1;
            end else begin
                m_left = G + S;
                m_cen  = 1'b0;
                m_pend = s;
            end
        end
        #1;
        check("is0", 32'(bus8.is0), 32'(m_is0));
        check("cen", 32'(bus8.cen), 32'(m_cen));
        check("done", 32'(bus8.done), 32'(m_done));
        check("sw_cnt", 32'(bus8.sw_cnt), 32'(m_cnt % 256));
        check("is0_w2", 32'(bus2.is0), 32'(m_is0));
        check("cen_w2", 32'(bus2.cen), 32'(m_cen));
        check("done_w2", 32'(bus2.done), 32'(m_done));
        check("sw_cnt_w2", 32'(bus2.sw_cnt), 32'(m_cnt % 4));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_left != 0 && n < 20) begin
            cycle(1'b0, 1'b0, 1'b0);
            n++;
        end
        check("idle_timeout", 32'(m_left), 32'd0);
    endtask

    // IS0 must never change while CEN is high. A reset edge is exempt.
    logic p_is0, p_cen, p_is0_2, p_cen_2;
    always @(posedge clk) begin
        automatic logic r_edge = rst;
        #1;
        if (started && !r_edge) begin
            check("is0_while_cen", 32'(((bus8.is0 !== p_is0) && p_cen) ||
                                       ((bus2.is0 !== p_is0_2) && p_cen_2)), 32'd0);
        end
        p_is0   = bus8.is0;
        p_cen   = bus8.cen;
        p_is0_2 = bus2.is0;
        p_cen_2 = bus2.cen;
    end

    initial begin
        bus8.req_vld = 1'b0;
        bus8.req_sel = 1'b0;
        bus2.req_vld = 1'b0;
        bus2.req_sel = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        started = 1'b1;

        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);

        // Real switch, then hold valid with toggling select across the busy window
        cycle(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < G + S; i++) cycle(1'b0, 1'b1, 1'(i));
        wait_idle();

        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, m_is0);
        cycle(1'b0, 1'b0, 1'b0);

        // Reset five edges after an accept
        cycle(1'b0, 1'b1, ~m_is0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        // Four real switches from a zero count wrap the 2-bit counter
        for (int i = 0; i < 4; i++) begin
            wait_idle();
            cycle(1'b0, 1'b1, ~m_is0);
        end
        wait_idle();

        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 2) != 0), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
